minn_peak_detector: RTL and testbench
=====================================

Name: minn_peak_detector

Overview:
- Consumes the windowed-sum / timing-metric stream produced by the Minn running-sum stage (`metric_valid`/`metric_in`, the other end of its `sum_valid`/`sum_out` interface).
- Detects the first threshold crossing and tracks the local maximum until SEARCH_LEN non-improving samples have followed it.
- Reports the peak value and its sample index as a one-cycle event, then ignores the stream for HOLDOFF_LEN samples.
- Feeds the OFDM frame-timing / symbol-start logic.

Parameters:
- METRIC_WIDTH, 20: signed width of `metric_in`, `threshold` and `peak_value`.
- IDX_WIDTH, 16: width of the free-running sample index; wraps modulo 2^IDX_WIDTH.
- SEARCH_LEN, 16: number of consecutive accepted samples without a new maximum that confirms a peak; must be ≥1.
- HOLDOFF_LEN, 64: number of accepted samples ignored after a peak is declared; 0 is legal.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- metric_valid  input  1  `metric_in` is accepted on this cycle (no backpressure)
- metric_in  input  METRIC_WIDTH  signed metric sample
- threshold  input  METRIC_WIDTH  signed detection threshold, read live each cycle
- peak_valid  output  1  one-cycle pulse: peak declared
- peak_value  output  METRIC_WIDTH  signed maximum metric; held until the next declaration
- peak_index  output  IDX_WIDTH  sample index of `peak_value`; held until the next declaration
- busy  output  1  state is not IDLE

Behaviour:
- Reset values:
  - state = IDLE; all outputs = 0.
  - `sample_idx`, `max_reg`, `max_idx`, `gap_cnt` and `hold_cnt` = 0.
- Sample index:
  - `sample_idx` is the index of the current accepted sample.
  - It increments by 1 after every accepted sample, in every state.
  - It wraps from 2^IDX_WIDTH−1 to 0 with no flag.
- Cycles with `metric_valid` = 0 change no state, counter or output, except that `peak_valid` returns to 0.
- Comparisons are signed, full METRIC_WIDTH. No arithmetic is performed, so there is no growth or saturation.
- IDLE:
  - On an accepted sample with `metric_in` > `threshold` (strict): go to TRACK, set `max_reg` = `metric_in`, `max_idx` = `sample_idx`, `gap_cnt` = 0.
  - Otherwise stay in IDLE.
- TRACK, on each accepted sample:
  - If `metric_in` > `max_reg` (strict): update `max_reg` and `max_idx`, and clear `gap_cnt`. Ties keep the earliest index.
  - Otherwise increment `gap_cnt`.
  - Samples below the threshold do not abort tracking; they only count as gap.
  - When the increment makes `gap_cnt` == SEARCH_LEN, declare the peak.
- Declaration:
  - On the next clock edge, set `peak_valid` = 1 for exactly one cycle.
  - On that same edge, load `peak_value` = `max_reg` and `peak_index` = `max_idx`.
  - Latency: `peak_valid` rises on the edge that accepts the SEARCH_LEN-th non-improving sample, so it is visible in the cycle after that sample was presented.
  - If HOLDOFF_LEN = 0, go to IDLE; otherwise go to HOLDOFF with `hold_cnt` = 0.
- HOLDOFF:
  - Each accepted sample increments `hold_cnt`; no threshold or max evaluation is done.
  - The sample that brings `hold_cnt` to HOLDOFF_LEN moves the state to IDLE.
  - The next accepted sample is the first one eligible to trigger.
- `threshold` may change at any cycle. It affects only the IDLE trigger decision on that cycle.
- `rst` asserted mid-TRACK or mid-HOLDOFF: a pending peak is discarded, no `peak_valid` is produced, and all state returns to reset values on that edge.
- Index wrap while in TRACK: `max_idx` holds the raw wrapped value; no correction is applied.
- Counters are sized to hold SEARCH_LEN and HOLDOFF_LEN; `$clog2(N+1)` bits with a minimum of 1 bit.

Test Plan:
- SEARCH_LEN=4, HOLDOFF_LEN=8, threshold=100, stream 0,50,120,200,150,90,80,70 (valid every cycle, indices 0–7):
  - Trigger at index 2.
  - `peak_valid` pulses once, the cycle after index 7 is accepted, with `peak_value`=200 and `peak_index`=3.
  - `busy` stays high through HOLDOFF.
- Same stream followed by eight samples of 500, then 300: no detection during the 500s (holdoff); 300 at index 16 triggers TRACK.
- Tie case: 120,200,200,10,10,10 with threshold=100, SEARCH_LEN=4 → `peak_index`=1 (earliest of the equal maxima), `peak_value`=200.
- Bubbles: repeat the first scenario with `metric_valid` toggling 1,0,1,0 → identical `peak_value`/`peak_index`; `peak_valid` is one cycle wide; indices count only valid samples.
- Reset mid-TRACK: assert `rst` after index 4 of the first scenario → no `peak_valid`, `busy`=0, and the next sample is index 0.
- Wrap: IDX_WIDTH=4; drive 17 below-threshold samples, then 150 followed by 4 samples of 0 → `peak_index`=1.

Source files
------------

// File: rtl/minn_peak_detector.sv
// minn_peak_detector: threshold-triggered peak search over the Minn timing metric,
// reporting the earliest maximum once SEARCH_LEN non-improving samples follow it.
module minn_peak_detector #(
    parameter int METRIC_WIDTH = 20,
    parameter int IDX_WIDTH    = 16,
    parameter int SEARCH_LEN   = 16,
    parameter int HOLDOFF_LEN  = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           metric_valid,
    input  logic signed [METRIC_WIDTH-1:0] metric_in,
    input  logic signed [METRIC_WIDTH-1:0] threshold,
    output logic                           peak_valid,
    output logic signed [METRIC_WIDTH-1:0] peak_value,
    output logic        [IDX_WIDTH-1:0]    peak_index,
    output logic                           busy
);
    localparam int GW = (SEARCH_LEN < 1) ? 1 : $clog2(SEARCH_LEN + 1);
    localparam int HW = (HOLDOFF_LEN < 1) ? 1 : $clog2(HOLDOFF_LEN + 1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLDOFF} state_t;

    state_t                          state_q;
    logic        [IDX_WIDTH-1:0]     sample_idx_q, max_idx_q;
    logic signed [METRIC_WIDTH-1:0]  max_q;
    logic        [GW-1:0]            gap_q, gap_d;
    logic        [HW-1:0]            hold_q, hold_d;

    assign gap_d  = gap_q + GW'(1);
    assign hold_d = hold_q + HW'(1);
    assign busy   = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_idx_q <= '0;
            max_q        <= '0;
            max_idx_q    <= '0;
            gap_q        <= '0;
            hold_q       <= '0;
            peak_valid   <= 1'b0;
            peak_value   <= '0;
            peak_index   <= '0;
        end else begin
            peak_valid <= 1'b0;
            if (metric_valid) begin
                sample_idx_q <= sample_idx_q + IDX_WIDTH'(1);
                case (state_q)
                    IDLE: if (metric_in > threshold) begin
                        state_q   <= TRACK;
                        max_q     <= metric_in;
                        max_idx_q <= sample_idx_q;
                        gap_q     <= '0;
                    end
                    TRACK: if (metric_in > max_q) begin
                        max_q     <= metric_in;
                        max_idx_q <= sample_idx_q;
                        gap_q     <= '0;
                    end else begin
                        gap_q <= gap_d;
                        // ties and sub-threshold samples only age the current maximum
                        if (gap_d == GW'(SEARCH_LEN)) begin
                            peak_valid <= 1'b1;
                            peak_value <= max_q;
                            peak_index <= max_idx_q;
                            hold_q     <= '0;
                            state_q    <= (HOLDOFF_LEN == 0) ? IDLE : HOLDOFF;
                        end
                    end
                    HOLDOFF: begin
                        hold_q <= hold_d;
                        if (hold_d == HW'(HOLDOFF_LEN)) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_minn_peak_detector.sv
// tb_minn_peak_detector: directed scenarios on two detector instances (16-bit and 4-bit
// index) sharing one stream, checked each cycle against a sample-history model.
module tb_minn_peak_detector;
    localparam int MW = 20;
    localparam int SL = 4;
    localparam int HL = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 metric_valid = 1'b0;
    logic signed [MW-1:0] metric_in = '0;
    logic signed [MW-1:0] threshold = 20'sd100;

    logic                 pv_a, busy_a, pv_b, busy_b;
    logic signed [MW-1:0] val_a, val_b;
    logic [15:0]          idx_a;
    logic [3:0]           idx_b;

    minn_peak_detector #(.METRIC_WIDTH(MW), .IDX_WIDTH(16), .SEARCH_LEN(SL), .HOLDOFF_LEN(HL)) dut_a (
        .clk(clk), .rst(rst), .metric_valid(metric_valid), .metric_in(metric_in), .threshold(threshold),
        .peak_valid(pv_a), .peak_value(val_a), .peak_index(idx_a), .busy(busy_a));

    minn_peak_detector #(.METRIC_WIDTH(MW), .IDX_WIDTH(4), .SEARCH_LEN(SL), .HOLDOFF_LEN(HL)) dut_b (
        .clk(clk), .rst(rst), .metric_valid(metric_valid), .metric_in(metric_in), .threshold(threshold),
        .peak_valid(pv_b), .peak_value(val_b), .peak_index(idx_b), .busy(busy_b));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remembers every sample since the trigger and picks the first maximum;
    // the peak is declared once SEARCH_LEN samples have followed that maximum.
    int mode = 0;
    int cnt = 0;
    int hold_left = 0;
    int qv[$];
    int qi[$];
    int exp_pv = 0;
    int exp_val = 0;
    int exp_idx = 0;

    always @(posedge clk) begin
        if (rst) begin
            mode = 0; cnt = 0; hold_left = 0;
            qv.delete(); qi.delete();
            exp_pv = 0; exp_val = 0; exp_idx = 0;
        end else begin
            exp_pv = 0;
            if (metric_valid) begin
                int v, p;
                v = int'(metric_in);
                if (mode == 0) begin
                    if (v > int'(threshold)) begin
                        mode = 1;
                        qv.delete(); qi.delete();
                        qv.push_back(v); qi.push_back(cnt);
                    end
                end else if (mode == 1) begin
                    qv.push_back(v); qi.push_back(cnt);
                    p = 0;
                    for (int k = 1; k < qv.size(); k++) if (qv[k] > qv[p]) p = k;
                    if (qv.size() - 1 - p == SL) begin
                        exp_pv = 1; exp_val = qv[p]; exp_idx = qi[p];
                        mode = (HL == 0) ? 0 : 2;
                        hold_left = HL;
                    end
                end else begin
                    hold_left--;
                    if (hold_left == 0) mode = 0;
                end
                cnt++;
            end
        end
    end

    always @(negedge clk) begin
        chk("a.peak_valid", int'(pv_a), exp_pv);
        chk("a.peak_value", int'(val_a), exp_val);
        chk("a.peak_index", int'(idx_a), exp_idx & 16'hFFFF);
        chk("a.busy", int'(busy_a), int'(mode != 0));
        chk("b.peak_valid", int'(pv_b), exp_pv);
        chk("b.peak_value", int'(val_b), exp_val);
        chk("b.peak_index", int'(idx_b), exp_idx & 4'hF);
        chk("b.busy", int'(busy_b), int'(mode != 0));
    end

    task automatic step(input logic vld, input int v);
        metric_valid = vld;
        metric_in = MW'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        metric_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic feed(input int n, input int v);
        for (int k = 0; k < n; k++) step(1'b1, v);
    endtask

    int s1[8] = '{0, 50, 120, 200, 150, 90, 80, 70};

    initial begin
        do_reset();
        chk("reset.peak_valid", int'(pv_a), 0);
        chk("reset.busy", int'(busy_a), 0);
        chk("reset.peak_value", int'(val_a), 0);
        chk("reset.peak_index", int'(idx_a), 0);

        // basic detection, holdoff, retrigger at index 16
        for (int k = 0; k < 8; k++) begin
            step(1'b1, s1[k]);
            if (k == 1) chk("s1.idle_before_trigger", int'(busy_a), 0);
            if (k == 2) chk("s1.trigger_busy", int'(busy_a), 1);
            if (k == 6) chk("s1.no_early_peak", int'(pv_a), 0);
        end
        chk("s1.peak_valid", int'(pv_a), 1);
        chk("s1.peak_value", int'(val_a), 200);
        chk("s1.peak_index", int'(idx_a), 3);
        chk("s1.model_value", exp_val, 200);
        chk("s1.model_index", exp_idx, 3);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 500);
            chk("s1.no_peak_in_holdoff", int'(pv_a), 0);
            if (k < 7) chk("s1.busy_in_holdoff", int'(busy_a), 1);
        end
        chk("s1.idle_after_holdoff", int'(busy_a), 0);
        step(1'b1, 300);
        chk("s1.retrigger", int'(busy_a), 1);
        feed(4, 0);
        chk("s1.second_value", int'(val_a), 300);
        chk("s1.second_index", int'(idx_a), 16);
        chk("s1.second_index_wrapped", int'(idx_b), 0);
        feed(8, 0);

        // ties keep the earliest index
        do_reset();
        step(1'b1, 120); step(1'b1, 200); step(1'b1, 200);
        step(1'b1, 10); step(1'b1, 10); step(1'b1, 10);
        chk("tie.peak_valid", int'(pv_a), 1);
        chk("tie.peak_value", int'(val_a), 200);
        chk("tie.peak_index", int'(idx_a), 1);
        feed(8, 0);

        // bubbles between every sample
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, s1[k]);
            if (k == 7) chk("bub.peak_valid", int'(pv_a), 1);
            step(1'b0, 999);
        end
        chk("bub.pulse_width", int'(pv_a), 0);
        chk("bub.peak_value", int'(val_a), 200);
        chk("bub.peak_index", int'(idx_a), 3);
        feed(8, 0);

        // reset mid-TRACK discards the pending peak and restarts indices
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, s1[k]);
        do_reset();
        chk("rst.busy", int'(busy_a), 0);
        step(1'b1, 90); step(1'b1, 80); step(1'b1, 70);
        chk("rst.no_peak", int'(pv_a), 0);
        do_reset();
        step(1'b1, 150);
        feed(4, 0);
        chk("rst.first_index_zero", int'(idx_a), 0);
        chk("rst.value", int'(val_a), 150);
        feed(8, 0);

        // equal-to-threshold and live threshold, then index wrap on the 4-bit instance
        do_reset();
        feed(15, 50);
        step(1'b1, 100);
        chk("thr.equal_no_trigger", int'(busy_a), 0);
        threshold = 20'sd160;
        step(1'b1, 150);
        chk("thr.live_no_trigger", int'(busy_a), 0);
        threshold = 20'sd100;
        step(1'b1, 150);
        feed(4, 0);
        chk("wrap.peak_valid", int'(pv_b), 1);
        chk("wrap.index4", int'(idx_b), 1);
        chk("wrap.index16", int'(idx_a), 17);
        feed(8, 0);

        // signed comparisons across zero
        do_reset();
        threshold = -20'sd50;
        step(1'b1, -100); step(1'b1, -20); step(1'b1, 3);
        step(1'b1, -5); step(1'b1, -6); step(1'b1, -7); step(1'b1, -8);
        chk("sign.peak_value", int'(val_a), 3);
        chk("sign.peak_index", int'(idx_a), 2);
        feed(8, 0);
        step(1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
